pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter FETCH_TIMEOUT, default 15, max cycles in FETCH without imem_ack before a fetch error (range 1..15).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 op  in  4  opcode, upper nibble of the instruction register, valid from DECODE onward.
REQ-005 imem_ack  in  1  instruction memory has the word on its data bus this cycle.
REQ-006 resume  in  1  one-cycle pulse that leaves HALT.
REQ-007 imem_req  out  1  instruction fetch request.
REQ-008 ir_we  out  1  instruction register load strobe.
REQ-009 pcsrc  out  3  next-PC select: BRZR=000, BRZI=100, JI=101, NO_JMP=110.
REQ-010 pc_we  out  1  PC register write enable.
REQ-011 rf_we  out  1  register file write enable.
REQ-012 halted  out  1  high while in HALT.
REQ-013 fetch_err  out  1  sticky fetch-timeout flag.
REQ-014 retire_cnt  out  8  retired-instruction count.

Function
REQ-015 States are BOOT, FETCH, DECODE, EXEC and HALT; outputs are Moore, decoded from the state, except where stated.
REQ-016 BOOT: all strobes 0, pcsrc=NO_JMP; the FSM goes unconditionally to FETCH next cycle.
REQ-017 FETCH: imem_req=1, and a 4-bit wait counter increments each cycle without ack.
  - On imem_ack: ir_we=1 in that same cycle (Mealy), the counter clears and the FSM goes to DECODE.
  - When the counter reaches FETCH_TIMEOUT without ack: fetch_err is set, the FSM goes to HALT and the counter clears.
  - If ack and timeout occur in the same cycle, ack wins.
REQ-018 imem_ack outside FETCH is ignored, with no strobe and no state change.
REQ-019 DECODE: all strobes 0; the FSM goes to EXEC unconditionally (one cycle).
REQ-020 EXEC drives outputs by op class:
  - OP_BRZR: pcsrc=BRZR, pc_we=1, rf_we=0.
  - OP_BRZI: pcsrc=BRZI, pc_we=1, rf_we=0.
  - OP_JI: pcsrc=JI, pc_we=1, rf_we=0.
  - Any other opcode except OP_HALT: pcsrc=NO_JMP, pc_we=1, rf_we=1.
  - Each of these cases then goes to FETCH.
REQ-021 Zero-flag qualification of branches is outside this block; pc_ctrl drives pcsrc regardless of zero.
REQ-022 EXEC with OP_HALT: pc_we=0, rf_we=0 and next state HALT, so the PC keeps the HALT address.
REQ-023 HALT: halted=1 and all strobes 0.
  - On resume: pc_we=1 with pcsrc=NO_JMP in that cycle (Mealy) and next state FETCH.
  - resume in any other state is ignored.
REQ-024 retire_cnt increments by 1 on each EXEC cycle with a non-HALT opcode and wraps from 255 to 0.
REQ-025 pcsrc equals NO_JMP in every state except EXEC with a branch or jump opcode.
REQ-026 fetch_err stays set until reset and does not block resume.
REQ-027 Cycles per instruction with zero-wait memory: 3 (FETCH, DECODE, EXEC).

Reset
REQ-028 While rst_n=0, state=BOOT, wait counter=0, retire_cnt=0 and fetch_err=0.
REQ-029 While rst_n=0, imem_req, ir_we, pc_we and rf_we are 0, halted=0 and pcsrc=NO_JMP.
REQ-030 Reset asserted mid-fetch or mid-EXEC aborts immediately; no strobe completes after rst_n falls.

Structure
REQ-031 A shared package holds:
  - the pcsrc encodings (BRZR, BRZI, JI, NO_JMP);
  - the opcode constants OP_BRZR=4'h0, OP_BRZI=4'h8, OP_JI=4'hA and OP_HALT=4'hF;
  - the FSM state encoding.
REQ-032 One sub-module, op_class_dec, maps op to a class (branch-reg, branch-imm, jump, halt, alu); it is purely combinational.

Verification
REQ-033 Scenario 1: release reset, tie imem_ack=1 and set op=4'h3.
  - Cycle 1: BOOT.
  - Cycle 2: imem_req=1 and ir_we=1.
  - Cycle 4: pc_we=1, rf_we=1, pcsrc=110.
  - retire_cnt=1 after cycle 4.
REQ-034 Scenario 2: with zero-wait memory, apply op=4'h0, then 4'h8, then 4'hA.
  - The EXEC cycles show pcsrc=000, 100, 101 respectively.
  - pc_we=1 and rf_we=0 in each of those EXEC cycles.
REQ-035 Scenario 3: hold imem_ack=0 in FETCH for 15 cycles.
  - fetch_err=1 and halted=1 on the next cycle.
  - Pulse resume: pc_we=1 in that cycle, then imem_req=1.
REQ-036 Scenario 4: run op=4'hF.
  - The EXEC cycle shows pc_we=0, then halted=1.
  - imem_ack pulses in HALT are ignored and retire_cnt is unchanged.
REQ-037 Scenario 5: run 256 non-HALT instructions; retire_cnt reads 0 afterwards.
REQ-038 Scenario 6: drop rst_n mid-FETCH with imem_ack=1 in the same cycle.
  - ir_we stays 0 and all outputs hold their reset values.
  - After release, the FSM restarts in BOOT.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter control FSM.
package pc_ctrl_pkg;

  // Next-PC select encodings driven towards the PC mux
  typedef enum logic [2:0] {
    PCSRC_BRZR   = 3'b000,
    PCSRC_BRZI   = 3'b100,
    PCSRC_JI     = 3'b101,
    PCSRC_NO_JMP = 3'b110
  } pcsrc_e;

  // Opcodes that the controller treats specially; everything else is ALU
  localparam logic [3:0] OP_BRZR = 4'h0;
  localparam logic [3:0] OP_BRZI = 4'h8;
  localparam logic [3:0] OP_JI   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Opcode classes produced by op_class_dec
  typedef enum logic [2:0] {
    CLS_BR_REG,
    CLS_BR_IMM,
    CLS_JUMP,
    CLS_HALT,
    CLS_ALU
  } op_class_e;

  // Controller FSM states
  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

endpackage

// File: rtl/pc_ctrl_if.sv
// Controller <-> datapath/instruction-memory signal bundle.
interface pc_ctrl_if;
  import pc_ctrl_pkg::*;

  logic [3:0] op;        // upper nibble of the instruction register
  logic       imem_ack;  // instruction word present on the bus this cycle
  logic       imem_req;  // fetch request
  logic       ir_we;     // instruction register load strobe
  pcsrc_e     pcsrc;     // next-PC select
  logic       pc_we;     // PC write enable
  logic       rf_we;     // register file write enable

  // Controller side
  modport master (
    input  op, imem_ack,
    output imem_req, ir_we, pcsrc, pc_we, rf_we
  );

  // Datapath / memory side
  modport slave (
    output op, imem_ack,
    input  imem_req, ir_we, pcsrc, pc_we, rf_we
  );
endinterface

// File: rtl/pc_ctrl_op_class_dec.sv
// Purely combinational opcode classifier.
module op_class_dec
  import pc_ctrl_pkg::*;
(
  input  logic [3:0] i_op,
  output op_class_e  o_class
);

  // Map the opcode nibble onto the class the controller acts on
  always_comb begin
    case (i_op)
      OP_BRZR: o_class = CLS_BR_REG;
      OP_BRZI: o_class = CLS_BR_IMM;
      OP_JI:   o_class = CLS_JUMP;
      OP_HALT: o_class = CLS_HALT;
      default: o_class = CLS_ALU;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter control FSM: BOOT -> FETCH -> DECODE -> EXEC, with a
// fetch timeout into HALT and a resume path back to FETCH.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 15  // 1..15 cycles without ack before error
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_ctrl_if.master        bus,
  input  logic             i_resume,
  output logic             o_halted,
  output logic             o_fetch_err,
  output logic [7:0]       o_retire_cnt
);

  // Counter value seen in the last FETCH cycle before the timeout fires
  localparam logic [3:0] TIMEOUT_LAST = 4'(FETCH_TIMEOUT - 1);

  state_e     r_state;
  state_e     w_next_state;
  logic [3:0] r_wait_cnt;
  logic       r_fetch_err;
  logic [7:0] r_retire_cnt;
  op_class_e  w_op_class;
  logic       w_timeout;
  logic       w_retire;

  op_class_dec u_op_class_dec (
    .i_op    (bus.op),
    .o_class (w_op_class)
  );

  // State register; reset aborts any in-flight fetch or execute at once
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_BOOT;
    else        r_state <= w_next_state;
  end

  // Next state, Moore strobes and the Mealy ir_we / resume pc_we
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    bus.imem_req = 1'b0;
    bus.ir_we    = 1'b0;
    bus.pcsrc    = PCSRC_NO_JMP;
    bus.pc_we    = 1'b0;
    bus.rf_we    = 1'b0;
    o_halted     = 1'b0;
    w_timeout    = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_BOOT: w_next_state = S_FETCH;
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          // ack beats a coincident timeout
          bus.ir_we    = 1'b1;
          w_next_state = S_DECODE;
        end else if (r_wait_cnt == TIMEOUT_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = S_HALT;
        end
      end
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
        bus.pc_we    = 1'b1;
        case (w_op_class)
          CLS_BR_REG: bus.pcsrc = PCSRC_BRZR;
          CLS_BR_IMM: bus.pcsrc = PCSRC_BRZI;
          CLS_JUMP:   bus.pcsrc = PCSRC_JI;
          CLS_HALT: begin
            // PC keeps the HALT address; not counted as retired
            bus.pc_we    = 1'b0;
            w_retire     = 1'b0;
            w_next_state = S_HALT;
          end
          default:    bus.rf_we = 1'b1;
        endcase
      end
      S_HALT: begin
        o_halted = 1'b1;
        if (i_resume) begin
          bus.pc_we    = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      default: w_next_state = S_BOOT;
    endcase
  end

  // Fetch wait counter: counts unacknowledged FETCH cycles, clear elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_wait_cnt <= 4'd0;
    else if (r_state != S_FETCH || bus.imem_ack || w_timeout) r_wait_cnt <= 4'd0;
    else                                             r_wait_cnt <= r_wait_cnt + 4'd1;
  end

  // Sticky fetch error and wrapping retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_err  <= 1'b0;
      r_retire_cnt <= 8'd0;
    end else begin
      if (w_timeout) r_fetch_err  <= 1'b1;
      if (w_retire)  r_retire_cnt <= r_retire_cnt + 8'd1;
    end
  end

  assign o_fetch_err  = r_fetch_err;
  assign o_retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed testbench for pc_ctrl.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  // Observed vector layout: {imem_req, ir_we, pc_we, rf_we, halted, pcsrc[2:0]}
  localparam logic [7:0] V_IDLE      = 8'b0000_0110;  // reset, BOOT, DECODE
  localparam logic [7:0] V_FETCH     = 8'b1000_0110;
  localparam logic [7:0] V_FETCH_ACK = 8'b1100_0110;
  localparam logic [7:0] V_EXEC_ALU  = 8'b0011_0110;
  localparam logic [7:0] V_EXEC_BRZR = 8'b0010_0000;
  localparam logic [7:0] V_EXEC_BRZI = 8'b0010_0100;
  localparam logic [7:0] V_EXEC_JI   = 8'b0010_0101;
  localparam logic [7:0] V_EXEC_HALT = 8'b0000_0110;
  localparam logic [7:0] V_HALT      = 8'b0000_1110;
  localparam logic [7:0] V_HALT_RES  = 8'b0010_1110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       resume;
  logic       halted;
  logic       fetch_err;
  logic [7:0] retire_cnt;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_retire = 8'd0;

  pc_ctrl_if u_if ();

  pc_ctrl #(.FETCH_TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (u_if.master),
    .i_resume     (resume),
    .o_halted     (halted),
    .o_fetch_err  (fetch_err),
    .o_retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {u_if.imem_req, u_if.ir_we, u_if.pc_we, u_if.rf_we, halted, 3'(u_if.pcsrc)};
  endfunction

  // Advance one cycle; inputs set afterwards apply to the new state
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; u_if.imem_ack = 1'b1; u_if.op = 4'h3; resume = 1'b0;
    tick(); tick();
    n_checks++; if (obs() !== V_IDLE) begin n_fail++; $display("FAIL rst_outs got=%b exp=%b", obs(), V_IDLE); end
    n_checks++; if ({fetch_err, retire_cnt} !== 9'd0) begin n_fail++; $display("FAIL rst_regs got=%b/%0d exp=0/0", fetch_err, retire_cnt); end
    rst_n = 1'b1; #1;
    n_checks++; if (obs() !== V_IDLE) begin n_fail++; $display("FAIL boot got=%b exp=%b", obs(), V_IDLE); end
  endtask

  // Scenario 1: one ALU instruction with zero-wait memory
  task automatic test_alu_first();
    tick();
    n_checks++; if (obs() !== V_FETCH_ACK) begin n_fail++; $display("FAIL s1_fetch got=%b exp=%b", obs(), V_FETCH_ACK); end
    tick();
    n_checks++; if (obs() !== V_IDLE) begin n_fail++; $display("FAIL s1_decode got=%b exp=%b", obs(), V_IDLE); end
    tick();
    n_checks++; if (obs() !== V_EXEC_ALU) begin n_fail++; $display("FAIL s1_exec got=%b exp=%b", obs(), V_EXEC_ALU); end
    tick(); exp_retire++;
    n_checks++; if (retire_cnt !== exp_retire) begin n_fail++; $display("FAIL s1_retire got=%0d exp=%0d", retire_cnt, exp_retire); end
  endtask

  // Scenario 2: branch/jump opcodes select their pcsrc in EXEC
  task automatic test_branches();
    logic [3:0] ops  [3] = '{4'h0, 4'h8, 4'hA};
    logic [7:0] exps [3] = '{V_EXEC_BRZR, V_EXEC_BRZI, V_EXEC_JI};
    for (int i = 0; i < 3; i++) begin
      u_if.op = ops[i]; #1;
      n_checks++; if (obs() !== V_FETCH_ACK) begin n_fail++; $display("FAIL br_fetch[%0d] got=%b exp=%b", i, obs(), V_FETCH_ACK); end
      tick(); tick();
      n_checks++; if (obs() !== exps[i]) begin n_fail++; $display("FAIL br_exec[%0d] got=%b exp=%b", i, obs(), exps[i]); end
      tick(); exp_retire++;
    end
    n_checks++; if (retire_cnt !== exp_retire) begin n_fail++; $display("FAIL br_retire got=%0d exp=%0d", retire_cnt, exp_retire); end
  endtask

  // Ack on the 15th wait cycle wins over the timeout; resume ignored outside HALT
  task automatic test_ack_wins();
    u_if.op = 4'h3; u_if.imem_ack = 1'b0;
    for (int i = 0; i < 14; i++) begin
      #1;
      n_checks++; if (obs() !== V_FETCH) begin n_fail++; $display("FAIL aw_wait[%0d] got=%b exp=%b", i, obs(), V_FETCH); end
      tick();
    end
    u_if.imem_ack = 1'b1; #1;
    n_checks++; if (obs() !== V_FETCH_ACK) begin n_fail++; $display("FAIL aw_ack got=%b exp=%b", obs(), V_FETCH_ACK); end
    tick();
    resume = 1'b1; #1;
    n_checks++; if ({obs(), fetch_err} !== {V_IDLE, 1'b0}) begin n_fail++; $display("FAIL aw_decode got=%b/%b exp=%b/0", obs(), fetch_err, V_IDLE); end
    resume = 1'b0;
    tick();
    n_checks++; if (obs() !== V_EXEC_ALU) begin n_fail++; $display("FAIL aw_exec got=%b exp=%b", obs(), V_EXEC_ALU); end
    tick(); exp_retire++;
    n_checks++; if (retire_cnt !== exp_retire) begin n_fail++; $display("FAIL aw_retire got=%0d exp=%0d", retire_cnt, exp_retire); end
  endtask

  // Scenario 3: 15 unacknowledged FETCH cycles -> HALT with fetch_err
  task automatic test_timeout();
    u_if.imem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      n_checks++; if ({obs(), fetch_err} !== {V_FETCH, 1'b0}) begin n_fail++; $display("FAIL to_wait[%0d] got=%b/%b exp=%b/0", i, obs(), fetch_err, V_FETCH); end
      tick();
    end
    n_checks++; if ({obs(), fetch_err} !== {V_HALT, 1'b1}) begin n_fail++; $display("FAIL to_halt got=%b/%b exp=%b/1", obs(), fetch_err, V_HALT); end
    resume = 1'b1; #1;
    n_checks++; if (obs() !== V_HALT_RES) begin n_fail++; $display("FAIL to_resume got=%b exp=%b", obs(), V_HALT_RES); end
    tick(); resume = 1'b0; #1;
    n_checks++; if ({obs(), fetch_err} !== {V_FETCH, 1'b1}) begin n_fail++; $display("FAIL to_refetch got=%b/%b exp=%b/1", obs(), fetch_err, V_FETCH); end
    n_checks++; if (retire_cnt !== exp_retire) begin n_fail++; $display("FAIL to_retire got=%0d exp=%0d", retire_cnt, exp_retire); end
  endtask

  // Scenario 4: HALT opcode; acks in HALT ignored, retire count frozen
  task automatic test_halt();
    u_if.op = 4'hF; u_if.imem_ack = 1'b1; #1;
    n_checks++; if (obs() !== V_FETCH_ACK) begin n_fail++; $display("FAIL h_fetch got=%b exp=%b", obs(), V_FETCH_ACK); end
    tick(); tick();
    n_checks++; if (obs() !== V_EXEC_HALT) begin n_fail++; $display("FAIL h_exec got=%b exp=%b", obs(), V_EXEC_HALT); end
    tick();
    for (int i = 0; i < 4; i++) begin
      u_if.imem_ack = ~u_if.imem_ack; #1;
      n_checks++; if (obs() !== V_HALT) begin n_fail++; $display("FAIL h_hold[%0d] got=%b exp=%b", i, obs(), V_HALT); end
      tick();
    end
    n_checks++; if (retire_cnt !== exp_retire) begin n_fail++; $display("FAIL h_retire got=%0d exp=%0d", retire_cnt, exp_retire); end
    resume = 1'b1; tick(); resume = 1'b0; u_if.op = 4'h3; u_if.imem_ack = 1'b1; #1;
    n_checks++; if (obs() !== V_FETCH_ACK) begin n_fail++; $display("FAIL h_resumed got=%b exp=%b", obs(), V_FETCH_ACK); end
  endtask

  // Scenario 5: 256 instructions from reset wrap retire_cnt back to 0
  task automatic test_wrap();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    tick();  // BOOT -> FETCH
    u_if.op = 4'h3; u_if.imem_ack = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      tick(); tick(); tick();
      if (n == 255) begin
        n_checks++; if (retire_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got=%0d exp=255", retire_cnt); end
      end
    end
    n_checks++; if ({retire_cnt, fetch_err} !== 9'd0) begin n_fail++; $display("FAIL wrap_0 got=%0d/%b exp=0/0", retire_cnt, fetch_err); end
  endtask

  // Scenario 6: reset dropped mid-FETCH while ack is high
  task automatic test_reset_mid_fetch();
    tick(); tick(); tick();  // one more instruction -> retire_cnt=1
    #1;
    n_checks++; if ({obs(), retire_cnt} !== {V_FETCH_ACK, 8'd1}) begin n_fail++; $display("FAIL mr_pre got=%b/%0d exp=%b/1", obs(), retire_cnt, V_FETCH_ACK); end
    rst_n = 1'b0; #1;
    n_checks++; if ({obs(), retire_cnt, fetch_err} !== {V_IDLE, 9'd0}) begin n_fail++; $display("FAIL mr_abort got=%b/%0d/%b exp=%b/0/0", obs(), retire_cnt, fetch_err, V_IDLE); end
    tick();
    n_checks++; if (obs() !== V_IDLE) begin n_fail++; $display("FAIL mr_hold got=%b exp=%b", obs(), V_IDLE); end
    rst_n = 1'b1; #1;
    n_checks++; if (obs() !== V_IDLE) begin n_fail++; $display("FAIL mr_boot got=%b exp=%b", obs(), V_IDLE); end
    tick();
    n_checks++; if (obs() !== V_FETCH_ACK) begin n_fail++; $display("FAIL mr_fetch got=%b exp=%b", obs(), V_FETCH_ACK); end
  endtask

  initial begin
    test_reset();
    test_alu_first();
    test_branches();
    test_ack_wins();
    test_timeout();
    test_halt();
    test_wrap();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
